// File: rtl/fpdlink_pkg.sv
// Shared constants, state encoding and helpers for the FPD-Link link controller.
package fpdlink_pkg;

    localparam int unsigned FPD_WORD_W = 7;
    localparam logic [FPD_WORD_W-1:0] FPD_CLK_PATTERN = 7'b1100011;

    localparam int unsigned FPD_RST_CYCLES    = 64;
    localparam int unsigned FPD_PLL_TIMEOUT   = 65535;
    localparam int unsigned FPD_SETTLE_CYCLES = 8;
    localparam int unsigned FPD_VERIFY_CYCLES = 256;
    localparam int unsigned FPD_ERR_LIMIT     = 4;
    localparam int unsigned FPD_SKIP_FRAMES   = 5;

    typedef enum logic [2:0] {
        ST_SERDES_RST = 3'd0,
        ST_WAIT_PLL   = 3'd1,
        ST_ALIGN      = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_VERIFY     = 3'd4,
        ST_LOCKED     = 3'd5
    } fpd_state_e;

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] fpd_sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/fpdlink_link_ctrl_if.sv
// Deserializer-side signal bundle of the link controller.
interface fpdlink_link_ctrl_if;

    logic                                pll_locked;
    logic [fpdlink_pkg::FPD_WORD_W-1:0]  clk_word;
    logic                                vsync;
    logic                                serdes_rst;
    logic                                bitslip;
    logic                                locked;
    logic                                frame_valid;
    logic [2:0]                          state;
    logic [7:0]                          relock_cnt;

    modport slave (
        input  pll_locked, clk_word, vsync,
        output serdes_rst, bitslip, locked, frame_valid, state, relock_cnt
    );

    modport master (
        output pll_locked, clk_word, vsync,
        input  serdes_rst, bitslip, locked, frame_valid, state, relock_cnt
    );

endinterface

// File: rtl/fpdlink_frame_gate.sv
// Counts vsync rising edges while locked and opens frame_valid on the first
// edge after SKIP_FRAMES edges have been discarded.
module fpdlink_frame_gate
    import fpdlink_pkg::*;
#(
    parameter int unsigned SKIP_FRAMES = FPD_SKIP_FRAMES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic vsync,
    output logic frame_valid
);

    localparam logic [2:0] SKIP_MAX = 3'(SKIP_FRAMES);

    logic       en_q;
    logic       last_vsync_q;
    logic [2:0] skip_q, skip_d;
    logic       fv_q, fv_d;
    logic       rise_s;

    // The first enabled cycle only loads last_vsync, so a vsync already high
    // on entry never counts as an edge.
    assign rise_s = en_q & vsync & ~last_vsync_q;

    // Skip counter and frame_valid next-state.
    always_comb begin
        skip_d = skip_q;
        fv_d   = fv_q;
        if (!enable) begin
            skip_d = 3'd0;
            fv_d   = 1'b0;
        end else if (rise_s) begin
            if (skip_q == SKIP_MAX) begin
                fv_d = 1'b1;
            end else begin
                skip_d = skip_q + 3'd1;
            end
        end else begin
            skip_d = skip_q;
            fv_d   = fv_q;
        end
    end

    // Edge-detect history, skip counter and frame_valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q         <= 1'b0;
            last_vsync_q <= 1'b0;
            skip_q       <= 3'd0;
            fv_q         <= 1'b0;
        end else begin
            en_q         <= enable;
            last_vsync_q <= vsync;
            skip_q       <= skip_d;
            fv_q         <= fv_d;
        end
    end

    assign frame_valid = fv_q;

endmodule

// File: rtl/fpdlink_link_ctrl.sv
// FPD-Link receiver bring-up supervisor: deserializer reset, PLL wait,
// bitslip alignment, lock verification and lock monitoring.
module fpdlink_link_ctrl
    import fpdlink_pkg::*;
#(
    parameter logic [FPD_WORD_W-1:0] CLK_PATTERN = FPD_CLK_PATTERN,
    parameter int unsigned RST_CYCLES    = FPD_RST_CYCLES,
    parameter int unsigned PLL_TIMEOUT   = FPD_PLL_TIMEOUT,
    parameter int unsigned SETTLE_CYCLES = FPD_SETTLE_CYCLES,
    parameter int unsigned VERIFY_CYCLES = FPD_VERIFY_CYCLES,
    parameter int unsigned ERR_LIMIT     = FPD_ERR_LIMIT,
    parameter int unsigned SKIP_FRAMES   = FPD_SKIP_FRAMES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpdlink_link_ctrl_if.slave   link_if
);

    localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] PLL_LAST    = 16'(PLL_TIMEOUT - 1);
    // The first SETTLE cycle carries the bitslip pulse; the wait follows it.
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES);
    localparam logic [15:0] VERIFY_LAST = 16'(VERIFY_CYCLES - 1);
    localparam logic [2:0]  ERR_LAST    = 3'(ERR_LIMIT - 1);

    logic                  pll_meta_q, pll_sync_q;
    logic [FPD_WORD_W-1:0] clk_word_q;
    fpd_state_e            state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [2:0]            slip_q, slip_d;
    logic [2:0]            err_q, err_d;
    logic [7:0]            relock_q, relock_d;
    logic                  serdes_rst_q, serdes_rst_d;
    logic                  bitslip_q, bitslip_d;
    logic                  locked_q, locked_d;
    logic                  match_s, pll_lost_s, relock_inc_s, gate_en_s;

    // Double-flop the asynchronous PLL lock and register the clock-lane word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_meta_q <= 1'b0;
            pll_sync_q <= 1'b0;
            clk_word_q <= 7'd0;
        end else begin
            pll_meta_q <= link_if.pll_locked;
            pll_sync_q <= pll_meta_q;
            clk_word_q <= link_if.clk_word;
        end
    end

    assign match_s = (clk_word_q == CLK_PATTERN);

    // Next state and counters; PLL loss outranks every other transition.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 16'd1;
        slip_d       = slip_q;
        err_d        = err_q;
        relock_inc_s = 1'b0;
        pll_lost_s   = !pll_sync_q && (state_q != ST_SERDES_RST) && (state_q != ST_WAIT_PLL);
        if (pll_lost_s) begin
            state_d      = ST_SERDES_RST;
            cnt_d        = 16'd0;
            relock_inc_s = (state_q == ST_ALIGN) || (state_q == ST_VERIFY) || (state_q == ST_LOCKED);
        end else begin
            case (state_q)
                ST_SERDES_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_PLL;
                        cnt_d   = 16'd0;
                    end else begin
                        state_d = ST_SERDES_RST;
                    end
                end
                ST_WAIT_PLL: begin
                    if (pll_sync_q) begin
                        state_d = ST_ALIGN;
                        cnt_d   = 16'd0;
                        slip_d  = 3'd0;
                    end else if (cnt_q == PLL_LAST) begin
                        state_d      = ST_SERDES_RST;
                        cnt_d        = 16'd0;
                        relock_inc_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT_PLL;
                    end
                end
                ST_ALIGN: begin
                    cnt_d = 16'd0;
                    if (match_s) begin
                        state_d = ST_VERIFY;
                    end else if (slip_q < 3'd6) begin
                        state_d = ST_SETTLE;
                        slip_d  = slip_q + 3'd1;
                    end else begin
                        state_d      = ST_SERDES_RST;
                        relock_inc_s = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_ALIGN;
                        cnt_d   = 16'd0;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
                ST_VERIFY: begin
                    if (!match_s) begin
                        state_d = ST_ALIGN;
                        cnt_d   = 16'd0;
                    end else if (cnt_q == VERIFY_LAST) begin
                        state_d = ST_LOCKED;
                        cnt_d   = 16'd0;
                        err_d   = 3'd0;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end
                ST_LOCKED: begin
                    cnt_d = 16'd0;
                    if (match_s) begin
                        err_d = 3'd0;
                    end else if (err_q == ERR_LAST) begin
                        state_d      = ST_SERDES_RST;
                        err_d        = 3'd0;
                        relock_inc_s = 1'b1;
                    end else begin
                        err_d = err_q + 3'd1;
                    end
                end
                default: begin
                    state_d = ST_SERDES_RST;
                    cnt_d   = 16'd0;
                end
            endcase
        end
    end

    // Output next values derived from the next state so the registered
    // outputs change in the same cycle as the state register.
    always_comb begin
        serdes_rst_d = (state_d == ST_SERDES_RST);
        bitslip_d    = (state_q == ST_ALIGN) && (state_d == ST_SETTLE);
        locked_d     = (state_d == ST_LOCKED);
        gate_en_s    = (state_d == ST_LOCKED);
        relock_d     = relock_inc_s ? fpd_sat_inc8(relock_q) : relock_q;
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SERDES_RST;
            cnt_q        <= 16'd0;
            slip_q       <= 3'd0;
            err_q        <= 3'd0;
            relock_q     <= 8'd0;
            serdes_rst_q <= 1'b1;
            bitslip_q    <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slip_q       <= slip_d;
            err_q        <= err_d;
            relock_q     <= relock_d;
            serdes_rst_q <= serdes_rst_d;
            bitslip_q    <= bitslip_d;
            locked_q     <= locked_d;
        end
    end

    fpdlink_frame_gate #(
        .SKIP_FRAMES (SKIP_FRAMES)
    ) u_frame_gate (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (gate_en_s),
        .vsync       (link_if.vsync),
        .frame_valid (link_if.frame_valid)
    );

    assign link_if.serdes_rst = serdes_rst_q;
    assign link_if.bitslip    = bitslip_q;
    assign link_if.locked     = locked_q;
    assign link_if.state      = state_q;
    assign link_if.relock_cnt = relock_q;

endmodule

// File: tb/tb_fpdlink_link_ctrl.sv
// Directed bench for the FPD-Link link controller.
module tb_fpdlink_link_ctrl;

    localparam logic [6:0] PAT = 7'b1100011;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;
    int   cyc;
    int   n_slips;
    int   slip_cyc [8];

    fpdlink_link_ctrl_if bus ();

    fpdlink_link_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .link_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] rotl1(input logic [6:0] w);
        return {w[5:0], w[6]};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One cycle; the deserializer model rotates its word on each bitslip.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.bitslip === 1'b1) begin
            if (n_slips < 8) slip_cyc[n_slips] = cyc;
            n_slips++;
            bus.clk_word = rotl1(bus.clk_word);
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int limit);
        int n;
        n = 0;
        while (bus.state !== st && n < limit) begin
            tick();
            n++;
        end
        if (bus.state !== st) check_val({tag, "_timeout"}, bus.state, st);
    endtask

    task automatic vsync_pulse(input int p);
        bus.vsync = 1'b1;
        tick();
        check_val($sformatf("fv_edge%0d", p), bus.frame_valid, (p >= 6) ? 1 : 0);
        tick();
        bus.vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic bad_words(input int k);
        bus.clk_word = 7'd0;
        repeat (k) tick();
        bus.clk_word = PAT;
    endtask

    initial begin
        int n_high;
        int n_ver;
        int n;
        logic [6:0] w;
        n_total = 0; n_bad = 0; cyc = 0; n_slips = 0;
        rst_n = 1'b0;
        bus.pll_locked = 1'b1;
        bus.clk_word   = PAT;
        bus.vsync      = 1'b1;
        repeat (3) tick();
        check_val("rst_serdes_rst", bus.serdes_rst, 1);
        check_val("rst_bitslip", bus.bitslip, 0);
        check_val("rst_locked", bus.locked, 0);
        check_val("rst_frame_valid", bus.frame_valid, 0);
        check_val("rst_state", bus.state, 0);
        check_val("rst_relock", bus.relock_cnt, 0);

        // Aligned bring-up
        rst_n = 1'b1;
        n_slips = 0;
        n_high = 0;
        while (bus.serdes_rst === 1'b1 && n_high < 200) begin
            n_high++;
            tick();
        end
        check_val("serdes_rst_len", n_high, 64);
        n_ver = 0; n = 0;
        while (bus.locked !== 1'b1 && n < 2000) begin
            if (bus.state == 3'd4) n_ver++;
            tick();
            n++;
        end
        check_val("lock1", bus.locked, 1);
        check_val("lock1_state", bus.state, 5);
        check_val("lock1_slips", n_slips, 0);
        check_val("verify_len", n_ver, 256);
        check_val("lock1_relock", bus.relock_cnt, 0);

        // Frame gating: vsync was high on entry and must not count
        bus.vsync = 1'b0;
        repeat (3) tick();
        check_val("fv_pre", bus.frame_valid, 0);
        for (int p = 1; p <= 7; p++) vsync_pulse(p);
        check_val("fv_hold", bus.frame_valid, 1);

        // Three mismatches are tolerated
        bad_words(3);
        repeat (5) tick();
        check_val("err3_locked", bus.locked, 1);
        check_val("err3_state", bus.state, 5);
        check_val("err3_fv", bus.frame_valid, 1);

        // Four mismatches drop lock
        bad_words(4);
        check_val("err4_pre_locked", bus.locked, 1);
        tick();
        check_val("err4_state", bus.state, 0);
        check_val("err4_locked", bus.locked, 0);
        check_val("err4_fv", bus.frame_valid, 0);
        check_val("err4_serdes_rst", bus.serdes_rst, 1);
        check_val("err4_relock", bus.relock_cnt, 1);

        // Word three phases off
        w = PAT;
        repeat (4) w = rotl1(w);
        bus.clk_word = w;
        n_slips = 0; n = 0;
        while (bus.locked !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        check_val("rot_slips", n_slips, 3);
        check_val("rot_gap1", slip_cyc[1] - slip_cyc[0], 10);
        check_val("rot_gap2", slip_cyc[2] - slip_cyc[1], 10);
        check_val("rot_locked", bus.locked, 1);
        check_val("rot_relock", bus.relock_cnt, 1);

        // PLL loss coinciding with the final verify match
        bad_words(4);
        tick();
        check_val("relock2", bus.relock_cnt, 2);
        wait_state("to_verify", 3'd4, 500);
        repeat (253) tick();
        check_val("pll_v254", bus.state, 4);
        bus.pll_locked = 1'b0;
        repeat (2) tick();
        check_val("pll_v256_state", bus.state, 4);
        check_val("pll_v256_locked", bus.locked, 0);
        tick();
        check_val("pll_drop_state", bus.state, 0);
        check_val("pll_drop_locked", bus.locked, 0);
        check_val("pll_drop_relock", bus.relock_cnt, 3);

        // Asynchronous reset while locked with video valid
        bus.pll_locked = 1'b1;
        wait_state("to_locked", 3'd5, 1000);
        for (int p = 1; p <= 6; p++) vsync_pulse(p);
        check_val("ar_pre_fv", bus.frame_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar_serdes_rst", bus.serdes_rst, 1);
        check_val("ar_locked", bus.locked, 0);
        check_val("ar_fv", bus.frame_valid, 0);
        check_val("ar_state", bus.state, 0);
        check_val("ar_relock", bus.relock_cnt, 0);

        // Unalignable word: exhaust phases, retry, saturate relock count
        bus.clk_word = 7'd0;
        tick();
        rst_n = 1'b1;
        n_slips = 0;
        wait_state("z_align", 3'd2, 200);
        wait_state("z_rst", 3'd0, 200);
        check_val("z_slips", n_slips, 6);
        check_val("z_relock", bus.relock_cnt, 1);
        n = 0;
        while (bus.relock_cnt !== 8'd255 && n < 40000) begin
            tick();
            n++;
        end
        check_val("z_relock_255", bus.relock_cnt, 255);
        repeat (300) tick();
        check_val("z_relock_sat", bus.relock_cnt, 255);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
